des_key_sched_rev: RTL and testbench

Iterative DES key scheduler for the decrypt path. It accepts a 64-bit DES key over a valid/ready handshake and applies PC-1 to it. It then emits the sixteen 48-bit round subkeys in reverse order (K16 first, K1 last), one per accepted beat. It sits between the key register and the Feistel round engine, undoing the forward key-bit selection order used on the encrypt side.

---
 rtl/des_pkg.sv | 44 ++++
 rtl/des_key_sched_rev_pc2.sv | 19 +
 rtl/des_key_sched_rev.sv | 106 ++++++++++
 tb/tb_des_key_sched_rev.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule tables (PC-1, PC-2, per-round rotations) and FSM state type.
// Encrypt-order support is compiled in with DES_KSCHED_ENC_EN.
package des_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // 1-based DES bit numbers: output bit i+1 takes input bit tab[i]
  localparam int pc1_tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] shift_dec [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] shift_enc [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // DES bit 1 sits at the MSB, so a DES left shift moves bits toward the MSB.
  function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] n,
                                        input logic left);
    logic [27:0] r;
    case (n)
      2'd1:    r = left ? {h[26:0], h[27]}    : {h[0],    h[27:1]};
      2'd2:    r = left ? {h[25:0], h[27:26]} : {h[1:0],  h[27:2]};
      default: r = h;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_sched_rev_pc2.sv
// PC-2 compression: 56-bit {C,D} to a 48-bit round subkey (DES bit 1 = MSB).
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - pc2_tab[i])];
    end
  end

endmodule

// File: rtl/des_key_sched_rev.sv
// Iterative DES key scheduler emitting K16..K1 for decryption.
// Define DES_KSCHED_ENC_EN to add an `enc` input that selects K1..K16 order instead.
module des_key_sched_rev
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
`ifdef DES_KSCHED_ENC_EN
  input  logic        enc,
`endif
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_last
);

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t      state;
  logic [27:0] c, d;
  logic [3:0]  cnt;
  logic        enc_q;
  logic        enc_in;
  logic [55:0] pc1_key;
  logic [47:0] pc2_out;
  logic [1:0]  load_amt, step_amt;
  logic [3:0]  cnt_nxt;

`ifdef DES_KSCHED_ENC_EN
  assign enc_in = enc;
`else
  assign enc_in = 1'b0;
`endif

  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

  always_comb begin
    pc1_key = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_key[6'(55 - i)] = key[6'(64 - pc1_tab[i])];
    end
  end

  assign cnt_nxt  = cnt + 4'd1;
  assign load_amt = enc_in ? shift_enc[0] : shift_dec[0];
  assign step_amt = enc_q ? shift_enc[cnt_nxt] : shift_dec[cnt_nxt];

  // Decrypt walks the halves back (right rotate); encrypt walks them forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      c     <= '0;
      d     <= '0;
      cnt   <= '0;
      enc_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            c     <= rot28(pc1_key[55:28], load_amt, enc_in);
            d     <= rot28(pc1_key[27:0],  load_amt, enc_in);
            cnt   <= '0;
            enc_q <= enc_in;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (sk_ready) begin
            if (cnt == LAST) begin
              state <= ST_IDLE;
            end else begin
              cnt <= cnt_nxt;
              c   <= rot28(c, step_amt, enq_dir(enc_q));
              d   <= rot28(d, step_amt, enq_dir(enc_q));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  function automatic logic enq_dir(input logic e);
    return e;
  endfunction

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (pc2_out)
  );

  assign key_ready = (state == ST_IDLE);
  assign sk_valid  = (state == ST_RUN);
  assign subkey    = sk_valid ? pc2_out : '0;
  assign sk_round  = sk_valid ? (enc_q ? cnt : LAST - cnt) : '0;
  assign sk_last   = sk_valid && (cnt == LAST);

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Directed bench for des_key_sched_rev using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_sched_rev;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
`ifdef DES_KSCHED_ENC_EN
  logic        enc;
`endif
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  sk_round;
  logic        sk_last;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h123456789ABCDEF0;
  localparam logic [63:0] KEY_ONE = 64'hFFFFFFFFFFFFFFFF;

  // K1..K16 of KEY_A, hand-derived
  logic [47:0] ktab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_sched_rev #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
`ifdef DES_KSCHED_ENC_EN
    .enc       (enc),
`endif
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .subkey    (subkey),
    .sk_round  (sk_round),
    .sk_last   (sk_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present key k, then consume nbeats subkeys; all_ones selects the all-ones expectation.
  task automatic run_key(input logic [63:0] k, input int nbeats, input bit rnd,
                         input bit hold_kv, input logic [63:0] alt,
                         input bit all_ones, input bit enc_mode);
    int idx;
    int budget;
    int r;
    logic [47:0] exp_sk;
    logic [3:0]  exp_rd;
    key_valid = 1'b1;
    key       = k;
`ifdef DES_KSCHED_ENC_EN
    enc = enc_mode;
`endif
    check_eq("accept_ready", {63'd0, key_ready}, 64'd1);
    tick();
    if (hold_kv) key = alt;
    else key_valid = 1'b0;
    idx    = 0;
    budget = 0;
    while (idx < nbeats && budget < 400) begin
      r = rnd ? int'($urandom_range(0, 1)) : 1;
      sk_ready = (r != 0);
      exp_rd = enc_mode ? 4'(idx) : 4'(15 - idx);
      exp_sk = all_ones ? 48'hFFFFFFFFFFFF : (enc_mode ? ktab[idx] : ktab[15 - idx]);
      check_eq($sformatf("sk_valid[%0d]", idx), {63'd0, sk_valid}, 64'd1);
      check_eq($sformatf("key_ready_run[%0d]", idx), {63'd0, key_ready}, 64'd0);
      check_eq($sformatf("subkey[%0d]", idx), {16'd0, subkey}, {16'd0, exp_sk});
      check_eq($sformatf("sk_round[%0d]", idx), {60'd0, sk_round}, {60'd0, exp_rd});
      check_eq($sformatf("sk_last[%0d]", idx), {63'd0, sk_last}, {63'd0, (idx == 15)});
      tick();
      if (r != 0) idx++;
      budget++;
    end
    if (idx < nbeats) check_eq("beat_timeout", 64'(idx), 64'(nbeats));
    if (nbeats == 16) begin
      check_eq("done_key_ready", {63'd0, key_ready}, 64'd1);
      check_eq("done_sk_valid", {63'd0, sk_valid}, 64'd0);
      check_eq("done_subkey", {16'd0, subkey}, 64'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key       = '0;
    sk_ready  = 1'b0;
`ifdef DES_KSCHED_ENC_EN
    enc = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_key_ready", {63'd0, key_ready}, 64'd1);
    check_eq("rst_sk_valid", {63'd0, sk_valid}, 64'd0);
    check_eq("rst_subkey", {16'd0, subkey}, 64'd0);
    check_eq("rst_sk_round", {60'd0, sk_round}, 64'd0);
    check_eq("rst_sk_last", {63'd0, sk_last}, 64'd0);
    rst = 1'b0;

    // full-rate decrypt sequence
    run_key(KEY_A, 16, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    // random backpressure
    run_key(KEY_A, 16, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    // key_valid held with a different key during RUN, then that key taken after K1
    run_key(KEY_A, 16, 1'b0, 1'b1, KEY_ONE, 1'b0, 1'b0);
    run_key(KEY_ONE, 16, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // reset after the 5th beat
    run_key(KEY_A, 5, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst_sk_valid", {63'd0, sk_valid}, 64'd0);
    check_eq("midrst_key_ready", {63'd0, key_ready}, 64'd1);
    check_eq("midrst_sk_last", {63'd0, sk_last}, 64'd0);
    check_eq("midrst_subkey", {16'd0, subkey}, 64'd0);
    tick();
    rst = 1'b0;
    run_key(KEY_A, 16, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // parity bits ignored
    run_key(KEY_PAR, 16, 1'b0, 1'b0, '0, 1'b0, 1'b0);

`ifdef DES_KSCHED_ENC_EN
    run_key(KEY_A, 16, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    run_key(KEY_A, 16, 1'b1, 1'b0, '0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
